// File: rtl/mppc_pulse_emulator.sv
// Burst pulse-train generator standing in for the MPPC discriminator output.
// Periodic or LFSR-randomised spacing; start is edge-detected through a 3-flop synchronizer.
module mppc_pulse_emulator #(
    parameter int          PERIOD_W = 24,
    parameter int          WIDTH_W  = 8,
    parameter int          COUNT_W  = 32,
    parameter logic [31:0] SEED     = 32'hACE1_2468
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH_W-1:0]  width,
    input  logic [COUNT_W-1:0]  n_pulses,
    output logic                pulse_out,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  sent_count
);
    // Wide enough for both max(width)+1 and a full random low time of 2^PERIOD_W.
    localparam int          CW        = ((PERIOD_W > WIDTH_W) ? PERIOD_W : WIDTH_W) + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_q0, r_q1, r_q2;
    logic                 w_start_pulse;
    logic [31:0]          r_lfsr;
    logic                 r_mode;
    logic [WIDTH_W-1:0]   r_w;
    logic [CW-1:0]        r_low_m1;
    logic [PERIOD_W-1:0]  r_mask;
    logic [COUNT_W-1:0]   r_n;
    logic [WIDTH_W-1:0]   r_hcnt, w_hcnt_nxt;
    logic [CW-1:0]        r_lcnt, w_lcnt_nxt;
    logic                 r_pulse, w_pulse_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [COUNT_W-1:0]   r_sent, w_sent_nxt;
    logic                 w_accept;
    logic [WIDTH_W-1:0]   w_w_eff;
    logic [CW-1:0]        w_w_ext, w_per_ext, w_p_eff, w_rand_m1;

    assign w_start_pulse = r_q1 & ~r_q2;
    assign w_w_eff       = (width == '0) ? WIDTH_W'(1) : width;
    assign w_w_ext       = CW'(w_w_eff);
    assign w_per_ext     = CW'(period);
    assign w_p_eff       = (w_per_ext > w_w_ext) ? w_per_ext : w_w_ext + CW'(1);
    assign w_rand_m1     = CW'(r_lfsr[PERIOD_W-1:0] & r_mask);

    // Counters hold "cycles remaining minus one"; a phase ends when its counter reads zero.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_lcnt_nxt  = r_lcnt;
        w_pulse_nxt = r_pulse;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sent_nxt  = r_sent;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_pulse && !abort) begin
                    w_accept   = 1'b1;
                    w_sent_nxt = '0;
                    if (n_pulses != '0) begin
                        w_state_nxt = HIGH;
                        w_pulse_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_sent_nxt  = COUNT_W'(1);
                        w_hcnt_nxt  = w_w_eff - WIDTH_W'(1);
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_pulse_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_hcnt != '0) begin
                    w_hcnt_nxt = r_hcnt - WIDTH_W'(1);
                end else if (r_sent == r_n) begin
                    w_state_nxt = IDLE;
                    w_pulse_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = LOW;
                    w_pulse_nxt = 1'b0;
                    w_lcnt_nxt  = r_mode ? w_rand_m1 : r_low_m1;
                end
            end
            LOW: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_pulse_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_lcnt != '0) begin
                    w_lcnt_nxt = r_lcnt - CW'(1);
                end else begin
                    w_state_nxt = HIGH;
                    w_pulse_nxt = 1'b1;
                    w_sent_nxt  = r_sent + COUNT_W'(1);
                    w_hcnt_nxt  = r_w - WIDTH_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pulse_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_q0     <= 1'b0;
            r_q1     <= 1'b0;
            r_q2     <= 1'b0;
            r_lfsr   <= SEED;
            r_mode   <= 1'b0;
            r_w      <= '0;
            r_low_m1 <= '0;
            r_mask   <= '0;
            r_n      <= '0;
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sent   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q0    <= start;
            r_q1    <= r_q0;
            r_q2    <= r_q1;
            r_lfsr  <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
            r_hcnt  <= w_hcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sent  <= w_sent_nxt;
            if (w_accept) begin
                r_mode   <= mode;
                r_w      <= w_w_eff;
                r_low_m1 <= w_p_eff - w_w_ext - CW'(1);
                r_mask   <= period;
                r_n      <= n_pulses;
            end
        end
    end

    assign pulse_out  = r_pulse;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sent_count = r_sent;
endmodule

// File: tb/tb_mppc_pulse_emulator.sv
// Directed bench for mppc_pulse_emulator: periodic, degenerate timing, abort, reset and random bursts.
module tb_mppc_pulse_emulator;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] period = '0;
    logic [7:0]  width = '0;
    logic [31:0] n_pulses = '0;
    logic        pulse_out, busy, done;
    logic [31:0] sent_count;
    logic [31:0] lfsr_m;

    int checks = 0;
    int failures = 0;

    mppc_pulse_emulator #(
        .PERIOD_W(24), .WIDTH_W(8), .COUNT_W(32), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .period(period), .width(width), .n_pulses(n_pulses),
        .pulse_out(pulse_out), .busy(busy), .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({pulse_out, busy, done, sent_count});
    endfunction

    // Leaves the bench on the cycle right after the first rising edge of pulse_out.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        tick();
        chk({tag, "_prerise"}, 64'(pulse_out), 64'(0));
        tick();
        start = 1'b0;
    endtask

    task automatic run_burst(input string tag, input logic m, input logic [23:0] per,
                             input logic [7:0] wid, input int n, input int we, input int pe,
                             input bit disturb);
        int last;
        int es;
        logic ep, eb, ed;
        mode = m; period = per; width = wid; n_pulses = 32'(n);
        launch(tag);
        last = (n - 1) * pe + we;
        for (int k = 0; k < last + 3; k++) begin
            ep = (k < last) && ((k % pe) < we);
            eb = (k < last);
            ed = (k == last);
            es = (k / pe + 1 > n) ? n : k / pe + 1;
            chk(tag, outs(), 64'({ep, eb, ed, 32'(es)}));
            if (disturb) begin
                start = (k >= 4 && k < 8);
                if (k == 1) begin
                    width = 8'd50; period = 24'd7; n_pulses = 32'd1; mode = 1'b1;
                end
            end
            tick();
        end
    endtask

    initial begin
        int m_rem, m_sent, rises, low_len;
        logic m_high, m_busy, m_done, prev_p, fin_seen;

        #12;
        chk("reset_outputs", outs(), 64'(0));
        chk("reset_lfsr", 64'(dut.r_lfsr), 64'(SEED));
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_burst("periodic", 1'b0, 24'd10, 8'd3, 4, 3, 10, 1'b0);
        run_burst("busy_restart", 1'b0, 24'd10, 8'd3, 4, 3, 10, 1'b1);

        mode = 1'b0; period = 24'd10; width = 8'd3; n_pulses = 32'd0;
        start = 1'b1;
        tick();
        tick();
        chk("zero_pre", outs(), 64'({1'b0, 1'b0, 1'b0, 32'd4}));
        tick();
        chk("zero_done", outs(), 64'({1'b0, 1'b0, 1'b1, 32'd0}));
        start = 1'b0;
        tick();
        chk("zero_after", outs(), 64'(0));
        repeat (3) tick();

        run_burst("illegal_w0p0", 1'b0, 24'd0, 8'd0, 3, 1, 2, 1'b0);
        run_burst("illegal_w5p3", 1'b0, 24'd3, 8'd5, 3, 5, 6, 1'b0);

        mode = 1'b0; period = 24'd20; width = 8'd4; n_pulses = 32'd10;
        launch("abort");
        repeat (41) tick();
        chk("abort_before", 64'({pulse_out, sent_count}), 64'({1'b1, 32'd3}));
        abort = 1'b1;
        tick();
        chk("abort_edge", outs(), 64'({1'b0, 1'b0, 1'b0, 32'd3}));
        abort = 1'b0;
        for (int k = 0; k < 25; k++) begin
            chk("abort_quiet", outs(), 64'({1'b0, 1'b0, 1'b0, 32'd3}));
            tick();
        end
        run_burst("abort_rerun", 1'b0, 24'd20, 8'd4, 2, 4, 20, 1'b0);

        n_pulses = 32'd5; width = 8'd2; period = 24'd4;
        abort = 1'b1;
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("start_abort_idle", outs(), 64'({1'b0, 1'b0, 1'b0, 32'd2}));
            tick();
        end

        mode = 1'b0; period = 24'd30; width = 8'd8; n_pulses = 32'd5;
        launch("rst_mid");
        tick();
        chk("rst_mid_high", 64'(pulse_out), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", outs(), 64'(0));
        chk("rst_lfsr", 64'(dut.r_lfsr), 64'(SEED));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_after", outs(), 64'(0));

        mode = 1'b1; period = 24'd15; width = 8'd2; n_pulses = 32'd64;
        launch("random");
        m_high = 1'b1; m_busy = 1'b1; m_done = 1'b0; m_rem = 2; m_sent = 1;
        rises = 0; low_len = 0; prev_p = 1'b0; fin_seen = 1'b0;
        for (int k = 0; k < 3000 && !fin_seen; k++) begin
            chk("rand_trace", outs(), 64'({m_high, m_busy, m_done, 32'(m_sent)}));
            if (pulse_out && !prev_p) begin
                rises++;
                if (rises > 1) chk("rand_low_range", 64'(low_len >= 1 && low_len <= 16), 64'(1));
                low_len = 0;
            end
            if (busy && !pulse_out) low_len++;
            prev_p = pulse_out;
            if (m_done) fin_seen = 1'b1;
            m_done = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_high && m_sent == 64) begin
                        m_high = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                    end else if (m_high) begin
                        m_high = 1'b0;
                        m_rem = int'(lfsr_m[23:0] & 24'd15) + 1;
                    end else begin
                        m_high = 1'b1; m_rem = 2; m_sent++;
                    end
                end
            end
            tick();
        end
        chk("rand_finished", 64'(fin_seen), 64'(1));
        chk("rand_rises", 64'(rises), 64'(64));
        chk("rand_sent", 64'(sent_count), 64'(64));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mppc_pulse_emulator.md
Name: mppc_pulse_emulator

Overview:
Programmable pulse-train generator that emulates MPPC discriminator output. It drives the disc_pulse input of the dark-counter chain so the full BCD counter and display path can be verified on-board without a sensor. A start edge launches a burst of N pulses, either with a fixed period or with pseudo-random spacing (LFSR) that mimics dark-count statistics. All logic runs on the on-board 100 MHz clock.

Parameters:
PERIOD_W, 24, width of period input and internal interval counter (must be ≤ 32)
WIDTH_W, 8, width of pulse-width input and high-time counter
COUNT_W, 32, width of n_pulses and sent_count
SEED, 32'hACE1_2468, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-high
start  in  1  push-button or switch level; asynchronous; rising edge launches a burst
abort  in  1  synchronous level; terminates an active burst
mode  in  1  0 = periodic, 1 = random spacing
period  in  PERIOD_W  rising-to-rising spacing in clk cycles (periodic mode) or spacing mask (random mode)
width  in  WIDTH_W  pulse high time in clk cycles
n_pulses  in  COUNT_W  number of pulses in the burst
pulse_out  out  1  registered emulated DISC pulse
busy  out  1  burst in progress
done  out  1  one-cycle strobe at normal burst completion
sent_count  out  COUNT_W  pulses emitted in the current or last burst

Behaviour:
- Reset (async): pulse_out=0, busy=0, done=0, sent_count=0, FSM=IDLE, all counters=0, synchronizer=0, LFSR=SEED.
- Start sync: q0<=start, q1<=q0, q2<=q1; start_pulse = q1 & ~q2. If E0 is the first clk edge sampling start=1, start_pulse is high between E0+1 and E0+2.
- Start acceptance: only in IDLE with abort=0. On acceptance, latch mode, width, period and n_pulses, and clear sent_count. Start edges during busy are ignored. If start and abort are both active in IDLE, abort wins and the start is dropped.
- Effective width: w = max(width, 1).
- Effective period: p = period if period > w, else w+1. This guarantees at least 1 low cycle.
- FSM states: IDLE, HIGH, LOW.
- IDLE -> HIGH on accepted start when n_pulses ≠ 0. On the same edge (E0+2): pulse_out=1, busy=1, sent_count=1, high counter loaded.
- IDLE with accepted start and n_pulses = 0: stay in IDLE, assert done for 1 cycle after E0+2, busy stays 0, no pulse.
- HIGH holds pulse_out=1 for exactly w cycles.
- HIGH exit when sent_count == n_l: go to IDLE. On that edge pulse_out=0, busy=0, done=1 (one cycle).
- HIGH exit otherwise: go to LOW with pulse_out=0.
- LOW length in periodic mode: p - w cycles, so rising edges are exactly p cycles apart.
- LOW length in random mode: 1 + (lfsr[PERIOD_W-1:0] & period), sampled on the HIGH->LOW edge. A 2^k-1 mask gives a uniform low time of 1..2^k cycles.
- LOW exit: go to HIGH, pulse_out=1, sent_count+1.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances every clk cycle.
- Abort: if abort=1 in HIGH or LOW, the next edge gives FSM=IDLE, pulse_out=0, busy=0. done is not asserted and sent_count holds its value.
- Overflow: sent_count never exceeds n_l, so it cannot wrap.
- Input stability: inputs other than start and abort are only sampled at acceptance. Changes during a burst have no effect.
- Reset mid-burst: pulse_out drops immediately and asynchronously, without waiting for a clk edge.

Test Plan:
- Periodic burst: mode=0, width=3, period=10, n=4, start edge at E0 -> pulse_out first rises after E0+2; 4 pulses, each high 3 cycles; rising edges 10 cycles apart; done single cycle on the edge the 4th pulse falls; busy falls on the same edge; sent_count=4.
- Zero-count burst: n=0, start -> no pulse; one-cycle done after E0+2; busy stays 0; sent_count=0.
- Illegal timing: width=0, period=0, n=3 -> high 1 cycle, low 1 cycle, period 2. Then width=5, period=3 -> high 5 cycles, low 1 cycle.
- Abort mid-burst: width=4, period=20, n=10; abort for 1 cycle during the 3rd HIGH -> pulse_out=0 and busy=0 next edge; sent_count=3; no done; a new start afterwards runs normally and sent_count restarts at 1.
- Robustness: second start edge while busy -> ignored (exactly n pulses emitted). Start and abort together in IDLE -> nothing launched. rst asserted mid-HIGH -> all outputs 0 immediately and LFSR = SEED.
- Random mode: mode=1, width=2, period=15, n=64, SEED default -> every low interval is in 1..16 and the full pulse sequence matches a cycle-accurate LFSR model; the dark-counter BCD output equals 64.
